// File: rtl/mobilenet_input_pkg.sv
// Shared types and constants for the MobileNet input stage (resizer -> image banks).
package mobilenet_input_pkg;

    localparam int unsigned OUT_DIM    = 224;
    localparam int unsigned IMG_PIXELS = OUT_DIM * OUT_DIM;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        READY
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DROP
    } writer_state_t;

    // Clamp a 10-bit signed difference to the signed int8 range.
    function automatic logic [7:0] sat8(input logic signed [9:0] d);
        if (d > 10'sd127) begin
            return 8'h7F;
        end else if (d < -10'sd128) begin
            return 8'h80;
        end else begin
            return d[7:0];
        end
    endfunction

endpackage

// File: rtl/pixel_quantize.sv
// Stage 1 of the bank writer: per-channel zero-point subtraction with int8
// saturation, registered. Output packing is {blueQ, greenQ, redQ}.
module pixel_quantize
    import mobilenet_input_pkg::*;
#(
    parameter int unsigned ZERO_POINT = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  inRed,
    input  logic [7:0]  inGreen,
    input  logic [7:0]  inBlue,
    output logic [23:0] qData
);

    localparam logic signed [9:0] ZP = $signed(10'(ZERO_POINT));

    logic signed [9:0] diff_r;
    logic signed [9:0] diff_g;
    logic signed [9:0] diff_b;
    logic [23:0]       q_next;

    // Subtract the zero point at 10 bits and saturate each channel.
    always_comb begin
        diff_r = $signed({2'b00, inRed})   - ZP;
        diff_g = $signed({2'b00, inGreen}) - ZP;
        diff_b = $signed({2'b00, inBlue})  - ZP;
        q_next = {sat8(diff_b), sat8(diff_g), sat8(diff_r)};
    end

    // Stage-1 data register.
    always_ff @(posedge clock) begin
        if (reset) begin
            qData <= '0;
        end else begin
            qData <= q_next;
        end
    end

endmodule

// File: rtl/image_bank_writer.sv
// Quantizes resized RGB pixels to int8 and writes them HWC-packed into one of
// two image banks, handing full banks to the first conv layer via a
// ready/release handshake. Optional macro PIXEL_COUNT_CHECK_EN discards banks
// whose pixel count is not exactly IMG_PIXELS and pulses frameError.
module image_bank_writer
    import mobilenet_input_pkg::*;
#(
    parameter int unsigned OUT_DIM    = 224,
    parameter int unsigned ZERO_POINT = 128,
    parameter int unsigned ADDR_WIDTH = 17
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            inRed,
    input  logic [7:0]            inGreen,
    input  logic [7:0]            inBlue,
    input  logic                  inPixelValid,
    input  logic                  endOfImage,
    output logic                  memWrEn,
    output logic [ADDR_WIDTH-1:0] memWrAddr,
    output logic [23:0]           memWrData,
    output logic                  imageAvailable,
    output logic                  readBank,
    input  logic                  bankRelease,
    output logic                  overflow,
    output logic [7:0]            droppedCount,
    output logic                  frameError
);

    localparam int unsigned           IMG_PIXELS = OUT_DIM * OUT_DIM;
    localparam logic [ADDR_WIDTH-1:0] IMG_PIX_A  = ADDR_WIDTH'(IMG_PIXELS);

    writer_state_t         state;
    writer_state_t         state_next;
    bank_state_t           bank_st [2];
    logic                  write_ptr;
    logic                  read_ptr;
    logic [ADDR_WIDTH-1:0] pix_count;
    logic [ADDR_WIDTH-1:0] addr_idx;

    logic release_fire;
    logic bank_free_w;
    logic start_fill;
    logic drop_img;
    logic fill_px;
    logic count_inc;
    logic end_fill;
    logic frame_bad;
    logic wr_fire;

    logic                  s1_wr_en;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  s1_end;
    logic                  s1_bad;
    logic                  s1_bank;
    logic [23:0]           q_data;

    assign imageAvailable = (bank_st[read_ptr] == READY);
    assign readBank       = read_ptr;
    assign release_fire   = bankRelease && imageAvailable;

    // A bank counts as free if it is FREE, is being released this cycle, or is
    // being returned to FREE this cycle by a rejected frame.
    assign bank_free_w = (bank_st[write_ptr] == FREE)
                      || (release_fire && (read_ptr == write_ptr))
                      || (s1_end && s1_bad && (s1_bank == write_ptr));

    assign wr_fire = start_fill || fill_px;

`ifdef PIXEL_COUNT_CHECK_EN
    logic [ADDR_WIDTH-1:0] cnt_after;
    assign cnt_after = pix_count + ADDR_WIDTH'(count_inc);
    assign frame_bad = end_fill && (cnt_after != IMG_PIX_A);
`else
    assign frame_bad = 1'b0;
`endif

    // Writer FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Writer FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inPixelValid) state_next = bank_free_w ? FILL : DROP;
            FILL:    if (endOfImage)   state_next = IDLE;
            DROP:    if (endOfImage)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Writer FSM outputs: per-cycle accept/drop/commit decisions.
    always_comb begin
        start_fill = 1'b0;
        drop_img   = 1'b0;
        fill_px    = 1'b0;
        count_inc  = 1'b0;
        end_fill   = 1'b0;
        addr_idx   = pix_count;
        case (state)
            IDLE: begin
                if (inPixelValid) begin
                    if (bank_free_w) begin
                        start_fill = 1'b1;
                        addr_idx   = '0;
                    end else begin
                        drop_img = 1'b1;
                    end
                end
            end
            FILL: begin
                if (inPixelValid) begin
                    fill_px   = (pix_count < IMG_PIX_A);
                    count_inc = (pix_count <= IMG_PIX_A);
                end
                end_fill = endOfImage;
            end
            default: ;
        endcase
    end

    // Pixel counter and write pointer; the counter saturates one past a full
    // image so an over-long frame stays distinguishable from a full one.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_count <= '0;
            write_ptr <= 1'b0;
        end else begin
            if (start_fill) begin
                pix_count <= ADDR_WIDTH'(1);
            end else if (count_inc) begin
                pix_count <= pix_count + ADDR_WIDTH'(1);
            end
            if (end_fill) begin
                pix_count <= '0;
                if (!frame_bad) write_ptr <= ~write_ptr;
            end
        end
    end

    // Read pointer advances on each accepted release.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_ptr <= 1'b0;
        end else if (release_fire) begin
            read_ptr <= ~read_ptr;
        end
    end

    // Bank states: a fill start overrides a same-cycle release or rejection
    // of that bank, which is what makes the free-bank bypass work.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (reset) begin
                bank_st[i] <= FREE;
            end else begin
                if (release_fire && (read_ptr == 1'(i))) begin
                    bank_st[i] <= FREE;
                end
                if (s1_end && (s1_bank == 1'(i))) begin
                    bank_st[i] <= s1_bad ? FREE : READY;
                end
                if (start_fill && (write_ptr == 1'(i))) begin
                    bank_st[i] <= FILLING;
                end
            end
        end
    end

    // Drop bookkeeping, visible the cycle after the rejected first pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow     <= 1'b0;
            droppedCount <= '0;
        end else if (drop_img) begin
            overflow <= 1'b1;
            if (droppedCount != 8'hFF) droppedCount <= droppedCount + 8'd1;
        end
    end

    pixel_quantize #(
        .ZERO_POINT (ZERO_POINT)
    ) u_quant (
        .clock   (clock),
        .reset   (reset),
        .inRed   (inRed),
        .inGreen (inGreen),
        .inBlue  (inBlue),
        .qData   (q_data)
    );

    // Stage 1: write strobe, bank address and end-of-image marker.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_wr_en <= 1'b0;
            s1_addr  <= '0;
            s1_end   <= 1'b0;
            s1_bad   <= 1'b0;
            s1_bank  <= 1'b0;
        end else begin
            s1_wr_en <= wr_fire;
            s1_addr  <= write_ptr ? (IMG_PIX_A + addr_idx) : addr_idx;
            s1_end   <= end_fill;
            s1_bad   <= frame_bad;
            s1_bank  <= write_ptr;
        end
    end

    // Stage 2: memory write port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            memWrEn   <= 1'b0;
            memWrAddr <= '0;
            memWrData <= '0;
        end else begin
            memWrEn   <= s1_wr_en;
            memWrAddr <= s1_addr;
            memWrData <= q_data;
        end
    end

`ifdef PIXEL_COUNT_CHECK_EN
    // Frame error pulse aligned with the bank returning to FREE.
    always_ff @(posedge clock) begin
        if (reset) begin
            frameError <= 1'b0;
        end else begin
            frameError <= s1_end && s1_bad;
        end
    end
`else
    assign frameError = 1'b0;
`endif

endmodule

// File: tb/tb_image_bank_writer.sv
// Directed bench for image_bank_writer with a small image (8x8) so full frames
// stay short; a second instance with ZERO_POINT=100 checks quantizer clamping.
module tb_image_bank_writer;

    localparam int unsigned DIM = 8;
    localparam int unsigned IMG = DIM * DIM;
    localparam int unsigned AW  = 17;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    inRed = '0;
    logic [7:0]    inGreen = '0;
    logic [7:0]    inBlue = '0;
    logic          inPixelValid = 1'b0;
    logic          endOfImage = 1'b0;
    logic          bankRelease = 1'b0;

    logic          memWrEn;
    logic [AW-1:0] memWrAddr;
    logic [23:0]   memWrData;
    logic          imageAvailable;
    logic          readBank;
    logic          overflow;
    logic [7:0]    droppedCount;
    logic          frameError;

    logic          memWrEn2;
    logic [AW-1:0] memWrAddr2;
    logic [23:0]   memWrData2;
    logic          imageAvailable2;
    logic          readBank2;
    logic          overflow2;
    logic [7:0]    droppedCount2;
    logic          frameError2;

    image_bank_writer #(
        .OUT_DIM    (DIM),
        .ZERO_POINT (128),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .inRed          (inRed),
        .inGreen        (inGreen),
        .inBlue         (inBlue),
        .inPixelValid   (inPixelValid),
        .endOfImage     (endOfImage),
        .memWrEn        (memWrEn),
        .memWrAddr      (memWrAddr),
        .memWrData      (memWrData),
        .imageAvailable (imageAvailable),
        .readBank       (readBank),
        .bankRelease    (bankRelease),
        .overflow       (overflow),
        .droppedCount   (droppedCount),
        .frameError     (frameError)
    );

    image_bank_writer #(
        .OUT_DIM    (DIM),
        .ZERO_POINT (100),
        .ADDR_WIDTH (AW)
    ) dut_zp100 (
        .clock          (clock),
        .reset          (reset),
        .inRed          (inRed),
        .inGreen        (inGreen),
        .inBlue         (inBlue),
        .inPixelValid   (inPixelValid),
        .endOfImage     (endOfImage),
        .memWrEn        (memWrEn2),
        .memWrAddr      (memWrAddr2),
        .memWrData      (memWrData2),
        .imageAvailable (imageAvailable2),
        .readBank       (readBank2),
        .bankRelease    (bankRelease),
        .overflow       (overflow2),
        .droppedCount   (droppedCount2),
        .frameError     (frameError2)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    int          wr_count = 0;
    int          addr_err = 0;
    logic [31:0] first_addr = '1;
    logic [31:0] last_addr = '1;
    logic [31:0] last_data = '0;
    logic [31:0] last_data2 = '0;

    always @(negedge clock) begin
        if (memWrEn === 1'b1) begin
            if (wr_count == 0) first_addr = 32'(memWrAddr);
            else if (32'(memWrAddr) != last_addr + 32'd1) addr_err++;
            last_addr  = 32'(memWrAddr);
            last_data  = 32'(memWrData);
            last_data2 = 32'(memWrData2);
            wr_count++;
        end
    end

    task automatic clear_mon();
        wr_count   = 0;
        addr_err   = 0;
        first_addr = '1;
        last_addr  = '1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n pixels back to back, then a one-cycle endOfImage (optionally with a
    // simultaneous bankRelease). Returns one cycle after endOfImage (E+1).
    task automatic send_image(input int n, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic rel);
        for (int k = 0; k < n; k++) begin
            inPixelValid = 1'b1;
            inRed = r; inGreen = g; inBlue = b;
            tick();
        end
        inPixelValid = 1'b0;
        endOfImage   = 1'b1;
        bankRelease  = rel;
        tick();
        endOfImage   = 1'b0;
        bankRelease  = 1'b0;
    endtask

    task automatic pulse_release();
        bankRelease = 1'b1;
        tick();
        bankRelease = 1'b0;
    endtask

    task automatic do_reset();
        inPixelValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_wren"},  32'(memWrEn), 0);
        check_eq({tag, "_addr"},  32'(memWrAddr), 0);
        check_eq({tag, "_data"},  32'(memWrData), 0);
        check_eq({tag, "_avail"}, 32'(imageAvailable), 0);
        check_eq({tag, "_rbank"}, 32'(readBank), 0);
        check_eq({tag, "_ovf"},   32'(overflow), 0);
        check_eq({tag, "_drop"},  32'(droppedCount), 0);
        check_eq({tag, "_ferr"},  32'(frameError), 0);
    endtask

    initial begin
        repeat (3) tick();
        check_zero("rst");
        reset = 1'b0;
        tick();

        // Image A -> bank 0
        clear_mon();
        send_image(IMG, 8'd200, 8'd128, 8'd0, 1'b0);
        check_eq("A_avail_e1", 32'(imageAvailable), 0);
        tick();
        check_eq("A_avail_e2", 32'(imageAvailable), 1);
        check_eq("A_rbank", 32'(readBank), 0);
        check_eq("A_count", wr_count, IMG);
        check_eq("A_first", first_addr, 0);
        check_eq("A_last", last_addr, IMG - 1);
        check_eq("A_seq", addr_err, 0);
        check_eq("A_data", last_data, 32'h800048);
        check_eq("A_data_zp100", last_data2, 32'h9C1C64);

        // Image B -> bank 1, saturating red
        clear_mon();
        send_image(IMG, 8'd255, 8'd0, 8'd128, 1'b0);
        tick();
        check_eq("B_count", wr_count, IMG);
        check_eq("B_first", first_addr, IMG);
        check_eq("B_last", last_addr, 2 * IMG - 1);
        check_eq("B_data", last_data, 32'h00807F);
        check_eq("B_data_zp100", last_data2, 32'h1C9C7F);
        check_eq("B_avail", 32'(imageAvailable), 1);
        check_eq("B_rbank", 32'(readBank), 0);

        // Image C: both banks READY -> dropped
        clear_mon();
        check_eq("C_ovf_pre", 32'(overflow), 0);
        inPixelValid = 1'b1;
        tick();
        check_eq("C_ovf_n1", 32'(overflow), 1);
        check_eq("C_drop_n1", 32'(droppedCount), 1);
        send_image(9, 8'd1, 8'd1, 8'd1, 1'b0);
        tick();
        check_eq("C_nowrite", wr_count, 0);
        check_eq("C_drop", 32'(droppedCount), 1);
        check_eq("C_avail", 32'(imageAvailable), 1);

        // Releases, including one ignored while nothing is available
        pulse_release();
        check_eq("R1_rbank", 32'(readBank), 1);
        check_eq("R1_avail", 32'(imageAvailable), 1);
        pulse_release();
        check_eq("R2_rbank", 32'(readBank), 0);
        check_eq("R2_avail", 32'(imageAvailable), 0);
        pulse_release();
        check_eq("R3_rbank", 32'(readBank), 0);
        check_eq("R3_avail", 32'(imageAvailable), 0);

        // Image D -> bank 0, zero channel with ZERO_POINT=100
        clear_mon();
        send_image(IMG, 8'd0, 8'd100, 8'd255, 1'b0);
        tick();
        check_eq("D_first", first_addr, 0);
        check_eq("D_data", last_data, 32'h7FE480);
        check_eq("D_data_zp100", last_data2, 32'h7F009C);
        check_eq("D_avail", 32'(imageAvailable), 1);

        // Image E -> bank 1 with release of bank 0 on its endOfImage
        clear_mon();
        send_image(IMG, 8'd10, 8'd20, 8'd30, 1'b1);
        check_eq("E_rbank_e1", 32'(readBank), 1);
        tick();
        check_eq("E_avail_e2", 32'(imageAvailable), 1);
        check_eq("E_rbank_e2", 32'(readBank), 1);
        check_eq("E_first", first_addr, IMG);
        check_eq("E_count", wr_count, IMG);
        check_eq("E_data", last_data, 32'h9E948A);

        // Reset in the middle of an image
        for (int k = 0; k < 20; k++) begin
            inPixelValid = 1'b1;
            inRed = 8'd7; inGreen = 8'd7; inBlue = 8'd7;
            tick();
        end
        do_reset();
        check_zero("midrst");
        clear_mon();
        send_image(IMG, 8'd200, 8'd128, 8'd0, 1'b0);
        tick();
        check_eq("F_first", first_addr, 0);
        check_eq("F_count", wr_count, IMG);
        check_eq("F_avail", 32'(imageAvailable), 1);
        check_eq("F_rbank", 32'(readBank), 0);

        // Over-long image: extra pixels discarded
        do_reset();
        clear_mon();
        send_image(IMG + 6, 8'd1, 8'd2, 8'd3, 1'b0);
        check_eq("G_ferr_e1", 32'(frameError), 0);
        tick();
        check_eq("G_count", wr_count, IMG);
        check_eq("G_last", last_addr, IMG - 1);
`ifdef PIXEL_COUNT_CHECK_EN
        check_eq("G_ferr_e2", 32'(frameError), 1);
        check_eq("G_avail", 32'(imageAvailable), 0);
`else
        check_eq("G_ferr_e2", 32'(frameError), 0);
        check_eq("G_avail", 32'(imageAvailable), 1);
`endif
        tick();
        check_eq("G_ferr_e3", 32'(frameError), 0);

        // Short image, then a full one
        do_reset();
        clear_mon();
        send_image(50, 8'd4, 8'd5, 8'd6, 1'b0);
        check_eq("H_ferr_e1", 32'(frameError), 0);
        tick();
        check_eq("H_count", wr_count, 50);
        check_eq("H_last", last_addr, 49);
`ifdef PIXEL_COUNT_CHECK_EN
        check_eq("H_ferr_e2", 32'(frameError), 1);
        check_eq("H_avail", 32'(imageAvailable), 0);
`else
        check_eq("H_ferr_e2", 32'(frameError), 0);
        check_eq("H_avail", 32'(imageAvailable), 1);
`endif
        clear_mon();
        send_image(IMG, 8'd128, 8'd128, 8'd128, 1'b0);
        tick();
`ifdef PIXEL_COUNT_CHECK_EN
        check_eq("I_first", first_addr, 0);
`else
        check_eq("I_first", first_addr, IMG);
`endif
        check_eq("I_count", wr_count, IMG);
        check_eq("I_data", last_data, 32'h000000);
        check_eq("I_avail", 32'(imageAvailable), 1);
        check_eq("I_rbank", 32'(readBank), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_bank_writer.md
# image_bank_writer

Downstream stage of the 224×224 pixel resizer. Converts each averaged RGB pixel to signed int8 (zero-point subtraction with saturation) and writes it, HWC-packed, into one of two on-chip image banks. Hands completed banks to the MobileNet first convolution layer through a ready/release handshake, so the resizer can fill one bank while the network reads the other.

## Interface
Parameters:
- OUT_DIM, 224: image side in pixels; pixels per image IMG_PIXELS = OUT_DIM*OUT_DIM (50176).
- ZERO_POINT, 128: unsigned value subtracted from each 8-bit channel.
- ADDR_WIDTH, 17: memory address width; must satisfy 2^ADDR_WIDTH ≥ 2*IMG_PIXELS.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- inRed / inGreen / inBlue  in  8 each  resized pixel channels.
- inPixelValid  in  1  pixel qualifier.
- endOfImage  in  1  one-cycle pulse after the last pixel of an image.
- memWrEn  out  1  bank memory write strobe.
- memWrAddr  out  ADDR_WIDTH  bank*IMG_PIXELS + pixel index.
- memWrData  out  24  {blueQ, greenQ, redQ}, each signed int8.
- imageAvailable  out  1  bank at readBank holds a complete image.
- readBank  out  1  bank the consumer must read next.
- bankRelease  in  1  one-cycle pulse: consumer done with readBank.
- overflow  out  1  sticky: at least one image dropped.
- droppedCount  out  8  dropped images, saturating at 255.
- frameError  out  1  one-cycle pulse on a pixel-count mismatch (see Configuration).

## Operation
- Per-bank state: FREE, FILLING, READY. Pointers: writePtr (next bank to fill) and readPtr (= readBank).
- Writer FSM:
  - IDLE: on inPixelValid, if bank[writePtr] is FREE (or is being released this cycle), mark it FILLING, write the pixel at index 0, go FILL. Otherwise set overflow, increment droppedCount, go DROP.
  - FILL: each valid pixel writes at index pixCount and increments pixCount. Pixels with pixCount ≥ IMG_PIXELS are discarded. On endOfImage: commit the bank (FILLING→READY), flip writePtr, clear pixCount, go IDLE.
  - DROP: ignore pixels. On endOfImage go IDLE.
- endOfImage in IDLE is ignored.
- Quantize: q = sat8(signed{1'b0,ch} − ZERO_POINT). The difference is computed at 10 bits, then clamped to [−128,127].
- imageAvailable = (bank[readPtr] == READY).
- bankRelease while imageAvailable: the bank goes READY→FREE and readPtr flips. bankRelease while !imageAvailable is ignored.
- Simultaneous events:
  - Commit of one bank and release of the other in the same cycle: both take effect.
  - Release of bank[writePtr] in the same cycle as the first pixel: counts as free (bypass), so the image is not dropped.
- Reset (including mid-image):
  - Banks FREE, pointers 0, pixCount 0, FSM IDLE, pipeline flushed.
  - All outputs 0; overflow and droppedCount cleared.

## Timing
- Pipeline is 2 stages: a pixel valid in cycle N produces memWrEn/addr/data in cycle N+2. memWrEn is high for exactly one cycle per accepted pixel.
- Throughput: one pixel per cycle, no backpressure to the resizer.
- endOfImage in cycle E travels down the same pipeline: the bank reads READY and imageAvailable rises in cycle E+2, after the last write.
- bankRelease in cycle R: imageAvailable and readBank update in cycle R+1.
- overflow and droppedCount update in cycle N+1 after a dropping first pixel.

## Configuration
- PIXEL_COUNT_CHECK_EN defined:
  - At endOfImage in FILL, if pixCount ≠ IMG_PIXELS (short, or overflowed past IMG_PIXELS), the bank returns to FREE instead of READY.
  - writePtr does not flip.
  - frameError pulses in cycle E+2.
- PIXEL_COUNT_CHECK_EN undefined:
  - The bank is always committed.
  - frameError is tied to 0.

## Structure
- Package mobilenet_input_pkg holds:
  - bank_state_t (FREE, FILLING, READY).
  - writer_state_t (IDLE, FILL, DROP).
  - Shared constants OUT_DIM and IMG_PIXELS.
- Sub-module pixel_quantize: the 3-channel subtract/saturate logic, registered as stage 1. Stage 2 (address/strobe register) stays in the top module.

## Test plan
- One full image of constant pixel (200,128,0) → 50176 writes at addresses 0..50175 with data {0x80,0x00,0x48}. imageAvailable high at E+2, readBank=0.
- Channels 0 and 255 with ZERO_POINT=100 → redQ 0x9C (−100) and 0x7F (saturated).
- Two images with no release → bank 0 then bank 1 READY, second image's addresses start at 50176. A third image is dropped: overflow=1, droppedCount=1, no memWrEn.
- Bank 0 READY and bank 1 filling; bankRelease in the same cycle as bank 1's endOfImage → bank 0 FREE, readBank=1, imageAvailable stays high.
- Reset asserted mid-image (pixel 1000) → next cycle all outputs 0. The next image writes from address 0 into bank 0.
- With PIXEL_COUNT_CHECK_EN, an image of 50000 pixels → frameError pulse at E+2, imageAvailable stays 0, the next image reuses bank 0.
